dadd_wbuf: RTL and testbench

//   Write buffer directly downstream of the dadd stage. Captures each (addr, data) pair

---
 rtl/dadd_pkg.sv | 13 +
 rtl/dadd_wbuf_mem.sv | 26 ++
 rtl/dadd_wbuf.sv | 107 ++++++++++
 tb/tb_dadd_wbuf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dadd_pkg.sv
// rtl/dadd_pkg.sv - shared types and constants for the dadd stage and its write buffer
package dadd_pkg;

  localparam int DADD_WBUF_DEPTH_DEF = 8;
  localparam int DADD_DROPCNT_W      = 16;

  // One buffered write at the default dadd widths
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } dadd_entry_t;

endpackage

// File: rtl/dadd_wbuf_mem.sv
// rtl/dadd_wbuf_mem.sv - write buffer storage, one sync write port and one async read port
module dadd_wbuf_mem
  import dadd_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = DADD_WBUF_DEPTH_DEF,
  localparam int IWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [IWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is never reset; the pointers alone decide which entries are live
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dadd_wbuf.sv
// rtl/dadd_wbuf.sv - dadd write buffer FIFO; DADD_WBUF_DROPCNT_EN adds a saturating drop counter
module dadd_wbuf
  import dadd_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = DADD_WBUF_DEPTH_DEF,
  localparam int LWIDTH = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_in_en,
  input  logic [DWIDTH-1:0] wb_in,
  input  logic [AWIDTH-1:0] wb_in_addr,
  output logic              wb_out_valid,
  input  logic              wb_out_ready,
  output logic [DWIDTH-1:0] wb_out,
  output logic [AWIDTH-1:0] wb_out_addr,
  output logic              wb_full,
  output logic              wb_empty,
  output logic [LWIDTH-1:0] wb_level,
  output logic              wb_ovf,
`ifdef DADD_WBUF_DROPCNT_EN
  output logic [DADD_DROPCNT_W-1:0] wb_drop_cnt,
`endif
  input  logic              wb_ovf_clr
);

  localparam int IWIDTH = LWIDTH - 1;
  localparam int EWIDTH = AWIDTH + DWIDTH;
  localparam logic [LWIDTH-1:0] FULL_XOR = {1'b1, {IWIDTH{1'b0}}};

  logic [LWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              empty, full, pop, push, drop;
  logic [EWIDTH-1:0] head;

  // Occupancy flags from the extra pointer wrap bit; push/pop/drop decisions
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
    pop      = !empty && wb_out_ready;
    push     = wb_in_en && (!full || pop);
    drop     = wb_in_en && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + LWIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + LWIDTH'(1) : rd_ptr_q;
    ovf_d    = drop ? 1'b1 : (wb_ovf_clr ? 1'b0 : ovf_q);
  end

  // Pointer and sticky overflow state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  dadd_wbuf_mem #(
    .WIDTH (EWIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[IWIDTH-1:0]),
    .wdata ({wb_in_addr, wb_in}),
    .raddr (rd_ptr_q[IWIDTH-1:0]),
    .rdata (head)
  );

  assign wb_empty     = empty;
  assign wb_full      = full;
  assign wb_out_valid = !empty;
  assign wb_level     = wr_ptr_q - rd_ptr_q;
  assign wb_ovf       = ovf_q;
  assign wb_out       = empty ? '0 : head[DWIDTH-1:0];
  assign wb_out_addr  = empty ? '0 : head[EWIDTH-1:DWIDTH];

`ifdef DADD_WBUF_DROPCNT_EN
  logic [DADD_DROPCNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop count; a drop in the clear cycle restarts the count at 1
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (wb_ovf_clr)            drop_cnt_d = DADD_DROPCNT_W'(1);
      else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DADD_DROPCNT_W'(1);
    end else if (wb_ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign wb_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dadd_wbuf.sv
// tb/tb_dadd_wbuf.sv - self-checking bench for dadd_wbuf with a queue-based reference model
module tb_dadd_wbuf;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_in_en = 1'b0;
  logic [31:0] wb_in = '0;
  logic [31:0] wb_in_addr = '0;
  logic        wb_out_valid;
  logic        wb_out_ready = 1'b0;
  logic [31:0] wb_out;
  logic [31:0] wb_out_addr;
  logic        wb_full;
  logic        wb_empty;
  logic [3:0]  wb_level;
  logic        wb_ovf;
  logic        wb_ovf_clr = 1'b0;
`ifdef DADD_WBUF_DROPCNT_EN
  logic [15:0] wb_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dadd_wbuf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_in_en     (wb_in_en),
    .wb_in        (wb_in),
    .wb_in_addr   (wb_in_addr),
    .wb_out_valid (wb_out_valid),
    .wb_out_ready (wb_out_ready),
    .wb_out       (wb_out),
    .wb_out_addr  (wb_out_addr),
    .wb_full      (wb_full),
    .wb_empty     (wb_empty),
    .wb_level     (wb_level),
    .wb_ovf       (wb_ovf),
`ifdef DADD_WBUF_DROPCNT_EN
    .wb_drop_cnt  (wb_drop_cnt),
`endif
    .wb_ovf_clr   (wb_ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of {addr,data} entries
  logic [63:0] m_q[$];
  logic [63:0] m_acc[$];
  logic [63:0] dut_log[$];
  logic        m_ovf = 1'b0;
  int          m_cnt = 0;
  int          m_drops = 0;
  int          max_level = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      automatic bit pop  = (m_q.size() > 0) && wb_out_ready;
      automatic bit full = (m_q.size() == DEPTH);
      automatic bit push = wb_in_en && (!full || pop);
      automatic bit drop = wb_in_en && full && !pop;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({wb_in_addr, wb_in});
        m_acc.push_back({wb_in_addr, wb_in});
      end
      if (drop) begin
        m_drops++;
        m_ovf = 1'b1;
        m_cnt = wb_ovf_clr ? 1 : (m_cnt < 65535 ? m_cnt + 1 : 65535);
      end else if (wb_ovf_clr) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge
  always @(negedge clk) begin
    automatic logic [63:0] head = (m_q.size() > 0) ? m_q[0] : 64'd0;
    chk("valid", wb_out_valid, m_q.size() > 0);
    chk("empty", wb_empty, m_q.size() == 0);
    chk("full", wb_full, m_q.size() == DEPTH);
    chk("level", wb_level, m_q.size());
    chk("head_data", wb_out, head[31:0]);
    chk("head_addr", wb_out_addr, head[63:32]);
    chk("ovf", wb_ovf, m_ovf);
`ifdef DADD_WBUF_DROPCNT_EN
    chk("drop_cnt", wb_drop_cnt, m_cnt);
`endif
    if (int'(wb_level) > max_level) max_level = int'(wb_level);
    if (rst_n && wb_out_valid && wb_out_ready) dut_log.push_back({wb_out_addr, wb_out});
  end

  task automatic cyc(input bit en, input logic [31:0] addr, input logic [31:0] data,
                     input bit rdy, input bit clr);
    @(posedge clk);
    #2;
    wb_in_en     = en;
    wb_in_addr   = addr;
    wb_in        = data;
    wb_out_ready = rdy;
    wb_ovf_clr   = clr;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) cyc(0, 0, 0, 1, 0);
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: reset state
    @(negedge clk);
    chk("t1_empty", wb_empty, 1);
    chk("t1_level", wb_level, 0);
    chk("t1_valid", wb_out_valid, 0);
    chk("t1_out", wb_out, 0);
    chk("t1_addr", wb_out_addr, 0);
    chk("t1_ovf", wb_ovf, 0);

    // 2: single write, one-cycle latency, then pop
    cyc(1, 32'h10, 32'h5, 0, 0);
    idle();
    @(negedge clk);
    chk("t2_valid", wb_out_valid, 1);
    chk("t2_out", wb_out, 32'h5);
    chk("t2_addr", wb_out_addr, 32'h10);
    chk("t2_level", wb_level, 1);
    cyc(0, 0, 0, 1, 0);
    idle();
    @(negedge clk);
    chk("t2_empty", wb_empty, 1);

    // 3: fill, drop the 9th, drain in order
    for (int i = 1; i <= 8; i++) cyc(1, 32'h100 + i, i, 0, 0);
    cyc(1, 32'h109, 9, 0, 0);
    idle();
    @(negedge clk);
    chk("t3_full", wb_full, 1);
    chk("t3_level", wb_level, 8);
    chk("t3_ovf", wb_ovf, 1);
    dut_log.delete();
    drain();
    chk("t3_count", dut_log.size(), 8);
    for (int i = 0; i < dut_log.size(); i++) chk("t3_order", dut_log[i][31:0], i + 1);

    cyc(0, 0, 0, 0, 1);
    idle();
    @(negedge clk);
    chk("t3_ovf_clr", wb_ovf, 0);

    // 4: push while full with simultaneous pop
    for (int i = 0; i < 8; i++) cyc(1, 32'h200 + i, 32'h11 + i, 0, 0);
    dut_log.delete();
    cyc(1, 32'h2AA, 32'hA, 1, 0);
    idle();
    @(negedge clk);
    chk("t4_level", wb_level, 8);
    chk("t4_ovf", wb_ovf, 0);
    drain();
    chk("t4_count", dut_log.size(), 9);
    for (int i = 0; i < dut_log.size(); i++)
      chk("t4_order", dut_log[i][31:0], (i < 8) ? 32'h11 + i : 32'hA);

    // 5: continuous writes with toggling ready, wrapping the pointers
    m_acc.delete();
    dut_log.delete();
    m_drops = 0;
    max_level = 0;
    for (int i = 0; i < 20; i++) cyc(1, $urandom, $urandom, (i % 2) == 0, 0);
    drain();
    chk("t5_conserve", dut_log.size() + m_drops, 20);
    chk("t5_count", dut_log.size(), m_acc.size());
    for (int i = 0; i < dut_log.size() && i < m_acc.size(); i++) chk("t5_seq", dut_log[i], m_acc[i]);
    chk("t5_maxlvl", max_level <= DEPTH, 1);

    // Random traffic
    m_acc.delete();
    dut_log.delete();
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0);
    drain();
    chk("rand_count", dut_log.size(), m_acc.size());
    for (int i = 0; i < dut_log.size() && i < m_acc.size(); i++) chk("rand_seq", dut_log[i], m_acc[i]);

    // 6: reset mid-burst
    for (int i = 0; i < 5; i++) cyc(1, 32'h300 + i, i, 0, 0);
    idle();
    @(negedge clk);
    chk("t6_level5", wb_level, 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_empty", wb_empty, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_empty", wb_empty, 1);
    chk("t6_level", wb_level, 0);

`ifdef DADD_WBUF_DROPCNT_EN
    for (int i = 0; i < 8; i++) cyc(1, i, i, 0, 0);
    repeat (3) cyc(1, 32'hDEAD, 32'hBEEF, 0, 0);
    idle();
    @(negedge clk);
    chk("t6_cnt3", wb_drop_cnt, 3);
    cyc(0, 0, 0, 0, 1);
    idle();
    @(negedge clk);
    chk("t6_cnt0", wb_drop_cnt, 0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
